// File: rtl/uart_alu_top.sv
// UART-to-ALU loopback: stimulus TX -> RX -> operand/opcode collector -> ALU -> result TX.
// Shift opcodes (SRA/SRL) are present only when ALU_SHIFT_OPS_EN is defined.

module uart_alu_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tick_i,
  input  logic            start_i,
  input  logic [DBIT-1:0] data_i,
  output logic            tx_o,
  output logic            done_o
);
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_o    <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= START;
            s_q     <= '0;
            b_q     <= data_i;
            tx_o    <= 1'b0;
          end
        end
        START: begin
          if (tick_i) begin
            if (s_q == SW'(15)) begin
              state_q <= DATA;
              s_q     <= '0;
              n_q     <= '0;
              tx_o    <= b_q[0];
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_i) begin
            if (s_q == SW'(15)) begin
              s_q <= '0;
              b_q <= b_q >> 1;
              if (n_q == NW'(DBIT-1)) begin
                state_q <= STOP;
                tx_o    <= 1'b1;
              end else begin
                n_q  <= n_q + 1'b1;
                tx_o <= b_q[1];
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick_i) begin
            if (s_q == SW'(SB_TICK-1)) begin
              state_q <= IDLE;
              done_o  <= 1'b1;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

module uart_alu_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tick_i,
  input  logic            rx_i,
  output logic [DBIT-1:0] data_o,
  output logic            done_o
);
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic            rx_prev_q;

  assign data_o = b_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      rx_prev_q <= 1'b1;
      done_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      rx_prev_q <= rx_i;
      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_i) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (tick_i) begin
            if (s_q == SW'(7)) begin
              s_q <= '0;
              n_q <= '0;
              state_q <= rx_i ? IDLE : DATA;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_i) begin
            if (s_q == SW'(15)) begin
              s_q <= '0;
              b_q <= {rx_i, b_q[DBIT-1:1]};
              if (n_q == NW'(DBIT-1)) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick_i) begin
            if (s_q == SW'(SB_TICK-1)) begin
              state_q <= IDLE;
              done_o  <= 1'b1;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

module uart_alu_top #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int BAUD_DIV = 163,
  parameter int NB_OP    = 6
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_data,
  output logic            o_tx_2,
  output logic [DBIT-1:0] o_result_test,
  output logic [DBIT-1:0] o_dataA_test,
  output logic [DBIT-1:0] o_dataB_test,
  output logic [DBIT-1:0] o_op_test,
  output logic [DBIT-1:0] o_data_rx_interface_test
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(32'h20);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(32'h22);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(32'h24);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(32'h25);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(32'h26);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(32'h27);
`ifdef ALU_SHIFT_OPS_EN
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(32'h03);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(32'h02);
`endif

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, LOAD, SEND} if_state_t;

  logic [BW-1:0]   baud_cnt_q;
  logic            tick;
  logic            tx1_line;
  logic            tx1_done_unused;
  logic [DBIT-1:0] rx_data;
  logic            rx_done;
  logic            tx2_done;
  logic            tx2_start_q;
  if_state_t       if_state_q;
  logic [DBIT-1:0] a_q, b_q, op_q, result_q, rx_byte_q;
  logic [DBIT-1:0] alu_d;

  assign tick = (baud_cnt_q == BW'(BAUD_DIV-1));

  always_ff @(posedge i_clock) begin
    if (i_reset || tick) baud_cnt_q <= '0;
    else                 baud_cnt_q <= baud_cnt_q + 1'b1;
  end

  uart_alu_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_tx_stim (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .tick_i  (tick),
    .start_i (i_tx_start),
    .data_i  (i_data),
    .tx_o    (tx1_line),
    .done_o  (tx1_done_unused)
  );

  uart_alu_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_rx (
    .clk_i  (i_clock),
    .rst_i  (i_reset),
    .tick_i (tick),
    .rx_i   (tx1_line),
    .data_o (rx_data),
    .done_o (rx_done)
  );

  uart_alu_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_tx_result (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .tick_i  (tick),
    .start_i (tx2_start_q),
    .data_i  (result_q),
    .tx_o    (o_tx_2),
    .done_o  (tx2_done)
  );

  always_comb begin
    alu_d = '0;
    case (op_q[NB_OP-1:0])
      OP_ADD: alu_d = a_q + b_q;
      OP_SUB: alu_d = a_q - b_q;
      OP_AND: alu_d = a_q & b_q;
      OP_OR:  alu_d = a_q | b_q;
      OP_XOR: alu_d = a_q ^ b_q;
      OP_NOR: alu_d = ~(a_q | b_q);
`ifdef ALU_SHIFT_OPS_EN
      OP_SRA: alu_d = (b_q >= DBIT'(DBIT)) ? {DBIT{a_q[DBIT-1]}}
                                            : $unsigned($signed(a_q) >>> b_q);
      OP_SRL: alu_d = (b_q >= DBIT'(DBIT)) ? '0 : (a_q >> b_q);
`endif
      default: alu_d = '0;
    endcase
  end

  // Bytes arriving while the result is being sent fall through unhandled.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      if_state_q  <= WAIT_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      rx_byte_q   <= '0;
      tx2_start_q <= 1'b0;
    end else begin
      if (rx_done) rx_byte_q <= rx_data;
      case (if_state_q)
        WAIT_A: begin
          if (rx_done) begin
            a_q        <= rx_data;
            if_state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done) begin
            b_q        <= rx_data;
            if_state_q <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (rx_done) begin
            op_q       <= rx_data;
            if_state_q <= LOAD;
          end
        end
        LOAD: begin
          result_q    <= alu_d;
          tx2_start_q <= 1'b1;
          if_state_q  <= SEND;
        end
        SEND: begin
          tx2_start_q <= 1'b0;
          if (tx2_done) if_state_q <= WAIT_A;
        end
        default: if_state_q <= WAIT_A;
      endcase
    end
  end

  assign o_result_test            = result_q;
  assign o_dataA_test             = a_q;
  assign o_dataB_test             = b_q;
  assign o_op_test                = op_q;
  assign o_data_rx_interface_test = rx_byte_q;
endmodule

// File: tb/tb_uart_alu_top.sv
// Scoreboard bench for uart_alu_top: stimulus pushes expected ALU results, a serial
// monitor on o_tx_2 decodes each result frame and checks it against the queue.

module tb_uart_alu_top;
  localparam int BD  = 4;
  localparam int BIT = 16 * BD;
  localparam int GAP = 720;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       tx2;
  logic [7:0] res, da, db, dop, drx;

  always #10 clk = ~clk;

  uart_alu_top #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(BD), .NB_OP(6)) dut (
    .i_clock                  (clk),
    .i_reset                  (rst),
    .i_tx_start               (start),
    .i_data                   (data),
    .o_tx_2                   (tx2),
    .o_result_test            (res),
    .o_dataA_test             (da),
    .o_dataB_test             (db),
    .o_op_test                (dop),
    .o_data_rx_interface_test (drx)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    data  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check8({tag, "_result"}, res, 8'h00);
    check8({tag, "_dataA"}, da, 8'h00);
    check8({tag, "_dataB"}, db, 8'h00);
    check8({tag, "_op"}, dop, 8'h00);
    check8({tag, "_rx"}, drx, 8'h00);
    check_int({tag, "_tx2_idle"}, int'(tx2), 1);
  endtask

  task automatic wait_result(input string name);
    int budget = 4000;
    while (sb_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check_int({name, "_pending_results"}, sb_q.size(), 0);
    repeat (100) tick();
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] r);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.res = r;
    sb_q.push_back(e);
    send_byte(a, GAP);
    send_byte(b, GAP);
    send_byte(op, 0);
    wait_result(name);
  endtask

  // Result monitor: decodes each o_tx_2 frame mid-bit and scores it.
  initial begin
    logic [7:0] rx_byte;
    logic       start_bit, stop_bit;
    exp_t       e;
    forever begin
      @(negedge tx2);
      repeat (BIT / 2) @(posedge clk);
      #1;
      start_bit = tx2;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(posedge clk);
        #1;
        rx_byte[i] = tx2;
      end
      repeat (BIT) @(posedge clk);
      #1;
      stop_bit = tx2;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got byte %h, required no frame", rx_byte);
      end else begin
        e = sb_q.pop_front();
        check_int("frame_start_bit", int'(start_bit), 0);
        check_int("frame_stop_bit", int'(stop_bit), 1);
        check8("tx2_byte", rx_byte, e.res);
        check8("result_reg", res, e.res);
        check8("dataA_reg", da, e.a);
        check8("dataB_reg", db, e.b);
        check8("op_reg", dop, e.op);
      end
    end
  end

  initial begin
    int   budget;
    int   width;
    exp_t e;

    // Start held through reset: exactly one 0x55 frame after release.
    rst   = 1'b1;
    start = 1'b1;
    data  = 8'h55;
    repeat (50) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) tick();
    start = 1'b0;
    repeat (2 * GAP) tick();
    check8("start_in_reset_dataA", da, 8'h55);
    check8("start_in_reset_rx", drx, 8'h55);
    check8("start_in_reset_single_frame", db, 8'h00);
    check_int("start_in_reset_tx2_idle", int'(tx2), 1);

    do_reset(10);

    // ADD 0x55 + 0x01 with bit-width measurement of the 0x56 result frame.
    e.a = 8'h55; e.b = 8'h01; e.op = 8'h20; e.res = 8'h56;
    sb_q.push_back(e);
    send_byte(8'h55, GAP);
    send_byte(8'h01, GAP);
    send_byte(8'h20, 0);
    budget = 3000;
    while (tx2 !== 1'b0 && budget > 0) begin tick(); budget--; end
    budget = 2 * BIT + 20;
    while (tx2 !== 1'b1 && budget > 0) begin tick(); budget--; end
    width = 0;
    while (tx2 === 1'b1 && width < 4 * BIT) begin tick(); width++; end
    check_int("bits_1_2_width", width, 2 * BIT);
    width = 0;
    while (tx2 === 1'b0 && width < 4 * BIT) begin tick(); width++; end
    check_int("bit_3_width", width, BIT);
    wait_result("add");

    run_op("sub_wrap", 8'h10, 8'h20, 8'h22, 8'hF0);
`ifdef ALU_SHIFT_OPS_EN
    run_op("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
    run_op("srl", 8'hF0, 8'h04, 8'h02, 8'h0F);
    run_op("sra_big", 8'h80, 8'h09, 8'h03, 8'hFF);
`else
    run_op("sra", 8'h80, 8'h02, 8'h03, 8'h00);
    run_op("srl", 8'hF0, 8'h04, 8'h02, 8'h00);
    run_op("sra_big", 8'h80, 8'h09, 8'h03, 8'h00);
`endif
    run_op("nor", 8'hF0, 8'h0F, 8'h27, 8'h00);
    run_op("unknown_op", 8'hF0, 8'h0F, 8'h3F, 8'h00);
    run_op("xor", 8'h3C, 8'h0F, 8'h26, 8'h33);
    run_op("add_upper_bits", 8'hFF, 8'h02, 8'hE0, 8'h01);

    // Reset in the middle of the second byte's frame.
    send_byte(8'h77, GAP);
    send_byte(8'h66, 300);
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("midframe_reset");
    rst = 1'b0;
    tick();
    check_int("after_reset_tx2_idle", int'(tx2), 1);
    repeat (GAP) tick();
    check8("after_reset_no_stray_byte", drx, 8'h00);

    run_op("and_after_reset", 8'h0C, 8'h05, 8'h24, 8'h04);
    run_op("or", 8'h0C, 8'h05, 8'h25, 8'h0D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
